// File: rtl/booth_mul_sched.sv
// Two-requester round-robin front end feeding a sequential radix-4 Booth
// multiplier: one 32x32 signed product per 16 CALC cycles, held until taken.
module booth_mul_sched #(
   parameter logic RR_INIT = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [63:0] rsp_product,
   output logic        busy
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]  r_state;
   logic [63:0] r_mcand;
   logic [32:0] r_win;
   logic [63:0] r_acc;
   logic [3:0]  r_cnt;
   logic        r_op_id;
   logic        r_prio;
   logic        r_busy;
   logic        r_rsp_valid;
   logic        r_rsp_id;
   logic [63:0] r_rsp_product;

   logic        w_idle;
   logic        w_grant;
   logic        w_req0_ready;
   logic        w_req1_ready;
   logic        w_accept;
   logic [31:0] w_a;
   logic [31:0] w_b;
   logic [63:0] w_sum;
   logic        w_last;

   // Partial product selected by one overlapping 3-bit Booth window, modulo 2^64.
   function automatic logic [63:0] booth_term(input logic [2:0] digit, input logic [63:0] m);
      logic [63:0] t;
      case (digit)
         3'b001, 3'b010: t = m;
         3'b011:         t = m << 1;
         3'b100:         t = 64'd0 - (m << 1);
         3'b101, 3'b110: t = 64'd0 - m;
         default:        t = 64'd0;
      endcase
      return t;
   endfunction

   // Arbitration: a lone requester wins, a tie goes to the priority holder.
   always_comb begin
      w_idle = (r_state == S_IDLE);
      if (req0_valid && req1_valid) begin
         w_grant = r_prio;
      end else begin
         w_grant = req1_valid;
      end
      w_req0_ready = w_idle & ~w_grant & req0_valid;
      w_req1_ready = w_idle &  w_grant & req1_valid;
      w_accept     = w_req0_ready | w_req1_ready;
      if (w_grant) begin
         w_a = req1_a;
         w_b = req1_b;
      end else begin
         w_a = req0_a;
         w_b = req0_b;
      end
   end

   // Datapath combinational terms for the current Booth step.
   always_comb begin
      w_sum  = r_acc + booth_term(r_win[2:0], r_mcand);
      w_last = (r_cnt == 4'd15);
   end

   // Control FSM, Booth datapath and response registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_mcand       <= 64'd0;
         r_win         <= 33'd0;
         r_acc         <= 64'd0;
         r_cnt         <= 4'd0;
         r_op_id       <= 1'b0;
         r_prio        <= RR_INIT;
         r_busy        <= 1'b0;
         r_rsp_valid   <= 1'b0;
         r_rsp_id      <= 1'b0;
         r_rsp_product <= 64'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_mcand <= {{32{w_a[31]}}, w_a};
                  r_win   <= {w_b, 1'b0};
                  r_acc   <= 64'd0;
                  r_cnt   <= 4'd0;
                  r_op_id <= w_grant;
                  r_prio  <= ~w_grant;
                  r_busy  <= 1'b1;
                  r_state <= S_CALC;
               end
            end
            S_CALC: begin
               r_acc   <= w_sum;
               r_mcand <= r_mcand << 2;
               r_win   <= {{2{r_win[32]}}, r_win[32:2]};
               r_cnt   <= r_cnt + 4'd1;
               // The 16th digit completes the product; publish the post-add value.
               if (w_last) begin
                  r_state       <= S_DONE;
                  r_rsp_valid   <= 1'b1;
                  r_rsp_product <= w_sum;
                  r_rsp_id      <= r_op_id;
               end
            end
            S_DONE: begin
               if (rsp_ready) begin
                  r_state     <= S_IDLE;
                  r_rsp_valid <= 1'b0;
                  r_busy      <= 1'b0;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_rsp_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign req0_ready  = w_req0_ready;
   assign req1_ready  = w_req1_ready;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_id      = r_rsp_id;
   assign rsp_product = r_rsp_product;
   assign busy        = r_busy;

endmodule
